// File: rtl/cdb_pkg.sv
// Shared Common Data Bus types and default widths, used by cdb_arbiter
// and reservation_station.
package cdb_pkg;

  localparam int TAG_W           = 5;
  localparam int DATA_W          = 32;
  localparam int NUM_REQ_DEFAULT = 4;

  typedef struct packed {
    logic              valid;
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] data;
  } cdb_bus_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: the first set request at or after ptr
// (wrapping) wins; gnt is one-hot and gnt_idx is the encoded winner.
module rr_arbiter #(
  parameter  int NUM_REQ = cdb_pkg::NUM_REQ_DEFAULT,
  localparam int SRC_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic               en,
  input  logic [SRC_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [SRC_W-1:0]   gnt_idx,
  output logic               gnt_valid
);

  int idx;

  always_comb begin
    // NOTE: every output gets a default before the search loop; a path that
    // leaves one unassigned would infer a latch.
    gnt       = '0;
    gnt_idx   = '0;
    gnt_valid = 1'b0;
    idx       = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = (int'(ptr) + i) % NUM_REQ;
      if (en && !gnt_valid && req[idx]) begin
        gnt[idx]  = 1'b1;
        gnt_idx   = SRC_W'(idx);
        gnt_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Common Data Bus arbiter: round-robin grant among NUM_REQ producers and a
// registered broadcast stage. Define CDB_ARB_STATS_EN to add conflict_cnt.
module cdb_arbiter #(
  parameter  int NUM_REQ = cdb_pkg::NUM_REQ_DEFAULT,
  parameter  int TAG_W   = cdb_pkg::TAG_W,
  parameter  int DATA_W  = cdb_pkg::DATA_W,
  localparam int SRC_W   = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*TAG_W-1:0]  req_tag,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      cdb_valid,
  output logic [TAG_W-1:0]          cdb_tag,
  output logic [DATA_W-1:0]         cdb_data,
  output logic [SRC_W-1:0]          cdb_src
`ifdef CDB_ARB_STATS_EN
  ,
  output logic [15:0]               conflict_cnt
`endif
);

  logic [SRC_W-1:0]  ptr_q, ptr_d;
  logic              cdb_valid_q, cdb_valid_d;
  logic [TAG_W-1:0]  cdb_tag_q, cdb_tag_d;
  logic [DATA_W-1:0] cdb_data_q, cdb_data_d;
  logic [SRC_W-1:0]  cdb_src_q, cdb_src_d;

  logic [NUM_REQ-1:0] gnt;
  logic [SRC_W-1:0]   gnt_idx;
  logic               gnt_valid;

  // Reset is folded into the enable so no handshake completes while rst is high.
  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .req       (req_valid),
    .en        (!flush && !rst),
    .ptr       (ptr_q),
    .gnt       (gnt),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid)
  );

  assign req_ready = gnt;

  always_comb begin
    ptr_d       = ptr_q;
    cdb_valid_d = gnt_valid;
    cdb_tag_d   = cdb_tag_q;
    cdb_data_d  = cdb_data_q;
    cdb_src_d   = cdb_src_q;
    if (gnt_valid) begin
      ptr_d      = (gnt_idx == SRC_W'(NUM_REQ - 1)) ? '0 : gnt_idx + SRC_W'(1);
      cdb_tag_d  = req_tag[gnt_idx*TAG_W +: TAG_W];
      cdb_data_d = req_data[gnt_idx*DATA_W +: DATA_W];
      cdb_src_d  = gnt_idx;
    end
  end

  // NOTE: state flops use non-blocking assignments so every register samples
  // pre-edge values; the reset is asynchronous, hence in the sensitivity list.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q       <= '0;
      cdb_valid_q <= 1'b0;
      cdb_tag_q   <= '0;
      cdb_data_q  <= '0;
      cdb_src_q   <= '0;
    end else begin
      ptr_q       <= ptr_d;
      cdb_valid_q <= cdb_valid_d;
      cdb_tag_q   <= cdb_tag_d;
      cdb_data_q  <= cdb_data_d;
      cdb_src_q   <= cdb_src_d;
    end
  end

  assign cdb_valid = cdb_valid_q;
  assign cdb_tag   = cdb_tag_q;
  assign cdb_data  = cdb_data_q;
  assign cdb_src   = cdb_src_q;

`ifdef CDB_ARB_STATS_EN
  logic [15:0] conflict_cnt_q, conflict_cnt_d;

  // Saturating count of cycles where two or more producers compete.
  always_comb begin
    conflict_cnt_d = conflict_cnt_q;
    if (!flush && ($countones(req_valid) >= 2) && (conflict_cnt_q != 16'hFFFF))
      conflict_cnt_d = conflict_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) conflict_cnt_q <= '0;
    else     conflict_cnt_q <= conflict_cnt_d;
  end

  assign conflict_cnt = conflict_cnt_q;
`endif

endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter: vector table for grants plus a
// scoreboard queue of expected broadcasts, then an async-reset sequence.
module tb_cdb_arbiter;

  localparam int N  = 4;
  localparam int TW = 5;
  localparam int DW = 32;
  localparam int NV = 20;

  logic            clk;
  logic            rst;
  logic            flush;
  logic [N-1:0]    req_valid;
  logic [N*TW-1:0] req_tag;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    req_ready;
  logic            cdb_valid;
  logic [TW-1:0]   cdb_tag;
  logic [DW-1:0]   cdb_data;
  logic [1:0]      cdb_src;
`ifdef CDB_ARB_STATS_EN
  logic [15:0]     conflict_cnt;
`endif

  cdb_arbiter #(.NUM_REQ(N), .TAG_W(TW), .DATA_W(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .req_valid (req_valid),
    .req_tag   (req_tag),
    .req_data  (req_data),
    .req_ready (req_ready),
    .cdb_valid (cdb_valid),
    .cdb_tag   (cdb_tag),
    .cdb_data  (cdb_data),
    .cdb_src   (cdb_src)
`ifdef CDB_ARB_STATS_EN
    ,
    .conflict_cnt (conflict_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0] req;
    logic         flush;
    logic [N-1:0] ready;
  } vec_t;

  typedef struct packed {
    cdb_pkg::cdb_bus_t bus;
    logic [1:0]        src;
  } exp_t;

  logic [TW-1:0] pay_tag  [N];
  logic [DW-1:0] pay_data [N];
  vec_t          vecs [NV];
  exp_t          sb [$];
  int            tests;
  int            fails;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [1:0] onehot_idx(input logic [N-1:0] v);
    logic [1:0] r;
    r = 2'd0;
    for (int i = 0; i < N; i++) if (v[i]) r = 2'(i);
    return r;
  endfunction

  task automatic push_expected(input logic [N-1:0] ready);
    exp_t e;
    logic [1:0] w;
    w            = onehot_idx(ready);
    e.bus.valid  = (ready != '0);
    e.bus.tag    = pay_tag[w];
    e.bus.data   = pay_data[w];
    e.src        = w;
    sb.push_back(e);
  endtask

  task automatic pop_and_compare();
    exp_t e;
    if (sb.size() == 0) begin
      check("scoreboard_nonempty", 64'd0, 64'd1);
      return;
    end
    e = sb.pop_front();
    check("cdb_valid", 64'(cdb_valid), 64'(e.bus.valid));
    if (e.bus.valid) begin
      check("cdb_tag",  64'(cdb_tag),  64'(e.bus.tag));
      check("cdb_data", 64'(cdb_data), 64'(e.bus.data));
      check("cdb_src",  64'(cdb_src),  64'(e.src));
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    pay_tag  = '{5'd3, 5'd11, 5'd7, 5'd20};
    pay_data = '{32'h1111_0000, 32'h2222_0001, 32'hDEAD_BEEF, 32'h4444_0003};
    for (int i = 0; i < N; i++) begin
      req_tag[i*TW +: TW]  = pay_tag[i];
      req_data[i*DW +: DW] = pay_data[i];
    end

    // Idle, all-four fairness, single requester, wrap, flush, single again.
    for (int k = 0; k < 5; k++) vecs[k] = '{4'b0000, 1'b0, 4'b0000};
    for (int k = 5; k < 13; k++) vecs[k] = '{4'b1111, 1'b0, 4'(4'b0001 << ((k - 5) % 4))};
    vecs[13] = '{4'b0100, 1'b0, 4'b0100};
    vecs[14] = '{4'b1001, 1'b0, 4'b1000};
    vecs[15] = '{4'b1001, 1'b0, 4'b0001};
    vecs[16] = '{4'b0010, 1'b1, 4'b0000};
    vecs[17] = '{4'b0010, 1'b0, 4'b0010};
    vecs[18] = '{4'b0001, 1'b0, 4'b0001};
    vecs[19] = '{4'b0001, 1'b0, 4'b0001};

    rst       = 1'b1;
    flush     = 1'b0;
    req_valid = 4'b1111;
    #2;
    check("rst_req_ready", 64'(req_ready), 64'd0);
    check("rst_cdb_valid", 64'(cdb_valid), 64'd0);
    check("rst_cdb_tag",   64'(cdb_tag),   64'd0);
    check("rst_cdb_data",  64'(cdb_data),  64'd0);
    check("rst_cdb_src",   64'(cdb_src),   64'd0);
`ifdef CDB_ARB_STATS_EN
    check("rst_conflict_cnt", 64'(conflict_cnt), 64'd0);
`endif
    req_valid = 4'b0000;
    #10 rst = 1'b0;

    for (int i = 0; i <= NV; i++) begin
      @(posedge clk);
      #1;
      if (i > 0) pop_and_compare();
`ifdef CDB_ARB_STATS_EN
      if (i == 13) check("conflict_cnt_after_all4", 64'(conflict_cnt), 64'd8);
`endif
      if (i < NV) begin
        req_valid = vecs[i].req;
        flush     = vecs[i].flush;
        @(negedge clk);
        check($sformatf("req_ready_v%0d", i), 64'(req_ready), 64'(vecs[i].ready));
        push_expected(vecs[i].ready);
      end
    end

    // Back-to-back grants from ptr=1, then async reset between edges.
    req_valid = 4'b1111;
    @(negedge clk);
    check("b2b_ready_1", 64'(req_ready), 64'b0010);
    @(posedge clk);
    #1;
    check("b2b_src_1", 64'(cdb_src), 64'd1);
    @(negedge clk);
    check("b2b_ready_2", 64'(req_ready), 64'b0100);
    @(posedge clk);
    #1;
    check("b2b_valid_2", 64'(cdb_valid), 64'd1);
    check("b2b_src_2",   64'(cdb_src),   64'd2);
    #2 rst = 1'b1;
    #1;
    check("async_rst_cdb_valid", 64'(cdb_valid), 64'd0);
    check("async_rst_req_ready", 64'(req_ready), 64'd0);
`ifdef CDB_ARB_STATS_EN
    check("async_rst_conflict_cnt", 64'(conflict_cnt), 64'd0);
`endif
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("post_rst_ready_ptr0", 64'(req_ready), 64'b0001);
    @(posedge clk);
    #1;
    check("post_rst_cdb_valid", 64'(cdb_valid), 64'd1);
    check("post_rst_cdb_src",   64'(cdb_src),   64'd0);
    check("post_rst_cdb_tag",   64'(cdb_tag),   64'(pay_tag[0]));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
